// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch queue and decode.
//   PCW_DEF / INSTRW_DEF : default PC and instruction widths
//   OPC_HALT             : 5-bit major opcode of HALT (top bits of instr)
//   fetch_entry_t        : {instr, pc} pair as queued and handed to decode
package fetch_pkg;
   localparam int PCW_DEF    = 32;
   localparam int INSTRW_DEF = 16;

   localparam logic [4:0] OPC_HALT = 5'b00000;

   typedef struct packed {
      logic [INSTRW_DEF-1:0] instr;
      logic [PCW_DEF-1:0]    pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order instruction queue between fetch and decode.
//   clk, rst_n            : clock, async active-low reset
//   valid_in/instr_in/pc_in : instruction from fetch
//   flush                 : taken branch, drop everything queued and incoming
//   ready_in              : decode takes the head entry
//   stall_out             : tells fetch to hold its PC
//   valid_out/instr_out/pc_out : head entry to decode
//   count                 : occupied entries
//   halt_seen             : HALT enqueued, queue closed until flush/reset
//   overflow              : sticky, an instruction was dropped on a full queue
module fetch_decode_queue
   import fetch_pkg::*;
#(
   parameter int PCW    = PCW_DEF,
   parameter int INSTRW = INSTRW_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic [INSTRW-1:0]        instr_in,
   input  logic [PCW-1:0]           pc_in,
   input  logic                     flush,
   input  logic                     ready_in,
   output logic                     stall_out,
   output logic                     valid_out,
   output logic [INSTRW-1:0]        instr_out,
   output logic [PCW-1:0]           pc_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     halt_seen,
   output logic                     overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

   // Same layout as fetch_entry_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [INSTRW-1:0] instr;
      logic [PCW-1:0]    pc;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rptr_q, wptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            halt_q, ovf_q;
   logic            full, pop, push, is_halt;

   assign full    = (count_q == FULL);
   assign is_halt = (instr_in[INSTRW-1 -: 5] == OPC_HALT);

   // Flush wins: it suppresses both sides of the handshake this cycle.
   assign pop  = valid_out && ready_in && !flush;
   assign push = valid_in && !flush && !halt_q && (!full || pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         halt_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (flush) begin
         // overflow deliberately survives a flush; only reset clears it
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         if (push && is_halt) halt_q <= 1'b1;
         if (valid_in && !halt_q && full && !pop) ovf_q <= 1'b1;
      end
   end

   // Storage needs no reset; contents are only observed when count != 0.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{instr: instr_in, pc: pc_in};
   end

   assign valid_out = (count_q != '0);
   assign instr_out = mem_q[rptr_q].instr;
   assign pc_out    = mem_q[rptr_q].pc;
   assign count     = count_q;
   assign halt_seen = halt_q;
   assign overflow  = ovf_q;
   // Stall at DEPTH-1 so the last slot can absorb the fetch already in flight.
   assign stall_out = (count_q >= ALMOST) || halt_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [15:0] instr_in;
   logic [31:0] pc_in;
   logic        flush;
   logic        ready_in;
   logic        stall_out, valid_out, halt_seen, overflow;
   logic [15:0] instr_out;
   logic [31:0] pc_out;
   logic [2:0]  count;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   fetch_decode_queue #(.PCW(32), .INSTRW(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_in(instr_in),
      .pc_in(pc_in), .flush(flush), .ready_in(ready_in),
      .stall_out(stall_out), .valid_out(valid_out), .instr_out(instr_out),
      .pc_out(pc_out), .count(count), .halt_seen(halt_seen),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [15:0] ins, input logic [31:0] pc);
      valid_in = 1'b1; instr_in = ins; pc_in = pc;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 0; instr_in = '0; pc_in = '0;
      flush = 0; ready_in = 0;
      #12;
      check("rst_count", count, 0);
      check("rst_valid", valid_out, 0);
      check("rst_stall", stall_out, 0);
      check("rst_halt", halt_seen, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1'b1;
      tick();

      // fill with ready low
      push1(16'h8001, 32'h0);
      check("lat_valid", valid_out, 1);
      check("lat_head", instr_out, 16'h8001);
      check("stall_c1", stall_out, 0);
      push1(16'h8002, 32'h1);
      push1(16'h8003, 32'h2);
      check("cnt3", count, 3);
      check("stall_c3", stall_out, 1);
      push1(16'h8004, 32'h3);
      check("cnt4", count, 4);

      // full: push 0x9000 and pop 0x8001 together
      valid_in = 1; instr_in = 16'h9000; pc_in = 32'h4; ready_in = 1;
      check("sim_head", instr_out, 16'h8001);
      tick();
      valid_in = 0;
      check("sim_cnt", count, 4);
      check("sim_ovf", overflow, 0);
      check("pop1_i", instr_out, 16'h8002);
      check("pop1_p", pc_out, 32'h1);
      tick();
      check("pop2_i", instr_out, 16'h8003);
      check("pop2_p", pc_out, 32'h2);
      tick();
      check("pop3_i", instr_out, 16'h8004);
      check("pop3_p", pc_out, 32'h3);
      tick();
      check("pop4_i", instr_out, 16'h9000);
      check("pop4_p", pc_out, 32'h4);
      check("pop4_cnt", count, 1);
      tick();
      check("drain_cnt", count, 0);
      check("drain_valid", valid_out, 0);
      ready_in = 0;

      // overflow
      push1(16'h8001, 32'h10);
      push1(16'h8002, 32'h11);
      push1(16'h8003, 32'h12);
      push1(16'h8004, 32'h13);
      push1(16'hA000, 32'h14);
      check("ovf_set", overflow, 1);
      check("ovf_cnt", count, 4);
      ready_in = 1;
      for (int i = 0; i < 4; i++) begin
         check("ovf_pop", instr_out, 16'h8001 + 16'(i));
         tick();
      end
      check("ovf_drain", valid_out, 0);
      check("ovf_sticky", overflow, 1);
      ready_in = 0;
      do_reset();
      check("ovf_rst", overflow, 0);

      // HALT
      push1(16'h8001, 32'h20);
      push1(16'h0000, 32'h21);
      check("halt_seen", halt_seen, 1);
      check("halt_stall", stall_out, 1);
      push1(16'h8002, 32'h22);
      check("halt_cnt", count, 2);
      check("halt_ovf", overflow, 0);
      ready_in = 1;
      check("halt_pop1", instr_out, 16'h8001);
      tick();
      check("halt_pop2", instr_out, 16'h0000);
      check("halt_pop2v", valid_out, 1);
      tick();
      check("halt_empty", valid_out, 0);
      check("halt_hold", halt_seen, 1);
      ready_in = 0;

      // flush clears halt, then flush with 3 entries and concurrent traffic
      flush = 1; tick(); flush = 0;
      check("fl_halt_clr", halt_seen, 0);
      push1(16'h8011, 32'h30);
      push1(16'h8012, 32'h31);
      push1(16'h8013, 32'h32);
      check("fl_pre_cnt", count, 3);
      flush = 1; valid_in = 1; instr_in = 16'hB000; pc_in = 32'h33; ready_in = 1;
      tick();
      flush = 0; valid_in = 0; ready_in = 0;
      check("fl_cnt", count, 0);
      check("fl_valid", valid_out, 0);
      check("fl_stall", stall_out, 0);
      check("fl_halt", halt_seen, 0);
      push1(16'hC000, 32'h40);
      check("fl_post_v", valid_out, 1);
      check("fl_post_i", instr_out, 16'hC000);
      check("fl_post_p", pc_out, 32'h40);
      ready_in = 1; tick(); ready_in = 0;
      check("fl_post_cnt", count, 0);

      // async reset between edges
      push1(16'h8021, 32'h50);
      push1(16'h8022, 32'h51);
      check("ar_pre", count, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_cnt", count, 0);
      check("ar_valid", valid_out, 0);
      #1;
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
